// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache tag array.
//   - derivation helpers for tag width, set count, way-select and PLRU widths
//   - entry field layout: {tag, valid, dirty}, with the flags in the low bits
//   - sweep/lookup FSM state encoding
package cache_pkg;

  // FSM encoding
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Entry layout: the flags sit at fixed low positions so that their
  // positions do not depend on the tag width.
  localparam int DIRTY_POS = 0;
  localparam int VALID_POS = 1;
  localparam int TAG_LSB   = 2;

  function automatic int calc_tag_w(input int addr_w, input int idx_w, input int offset_w);
    return addr_w - idx_w - offset_w;
  endfunction

  function automatic int calc_idx_size(input int idx_w);
    return 1 << idx_w;
  endfunction

  function automatic int calc_way_w(input int ways);
    return (ways <= 1) ? 1 : $clog2(ways);
  endfunction

  // A 1-way array has no PLRU state; keep one (unused) bit so vectors stay legal.
  function automatic int calc_plru_w(input int ways);
    return (ways <= 1) ? 1 : ways - 1;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU helper (purely combinational).
//   plru_i       : current tree bits of one set, heap order (node 0 = root)
//   access_way_i : way being touched
//   plru_o       : tree bits with access_way_i made most-recently-used
//   victim_o     : way chosen for replacement from plru_i
// Node bit 0 means the left subtree was used more recently, so the victim
// walk goes right on 0 and left on 1.
module cache_plru
  import cache_pkg::*;
#(
  parameter  int WAYS   = 2,
  localparam int WAY_W  = calc_way_w(WAYS),
  localparam int PLRU_W = calc_plru_w(WAYS),
  localparam int LEVELS = (WAYS <= 1) ? 0 : $clog2(WAYS)
) (
  input  logic [PLRU_W-1:0] plru_i,
  input  logic [WAY_W-1:0]  access_way_i,
  output logic [PLRU_W-1:0] plru_o,
  output logic [WAY_W-1:0]  victim_o
);

  always_comb begin
    int   node;
    logic dir;
    // NOTE: every output and temporary gets a default before the loops so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    plru_o   = plru_i;
    victim_o = '0;
    dir      = 1'b0;

    // MRU update: on each node of the access path record which half was used.
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      dir          = access_way_i[LEVELS-1-l];
      plru_o[node] = dir;
      node         = 2 * node + 1 + int'(dir);
    end

    // Victim walk: always step into the less recently used half.
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      dir                   = ~plru_i[node];
      victim_o[LEVELS-1-l] = dir;
      node                  = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/cache_tag_array_nway.sv
// N-way set-associative tag store with hit detection, tree PLRU replacement
// and a valid/dirty sweep engine used for power-up init and flush.
//   iCLK, iRST_N        : clock, asynchronous active-low reset
//   req_*               : one lookup per cycle, response registered one cycle later
//   fill_*              : tag write port from the cache controller
//   flush_start         : invalidate-all request (ignored while busy)
//   busy                : sweep in progress, requests and fills dropped
//   resp_*, victim_*    : hit/way result plus the selected entry for write-back
module cache_tag_array_nway
  import cache_pkg::*;
#(
  parameter  int ADDR_W   = 32,
  parameter  int OFFSET_W = 2,
  parameter  int IDX_W    = 5,
  parameter  int WAYS     = 2,
  localparam int WAY_W    = calc_way_w(WAYS),
  localparam int TAG_W    = calc_tag_w(ADDR_W, IDX_W, OFFSET_W)
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic              fill_valid,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic              fill_dirty,
  input  logic              flush_start,
  output logic              busy,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              victim_valid,
  output logic              victim_dirty,
  output logic [TAG_W-1:0]  victim_tag
);

  localparam int IDX_SIZE = calc_idx_size(IDX_W);
  localparam int PLRU_W   = calc_plru_w(WAYS);
  localparam int ENTRY_W  = TAG_W + TAG_LSB;

  if (!(WAYS == 1 || WAYS == 2 || WAYS == 4 || WAYS == 8)) begin : g_bad_ways
    $error("cache_tag_array_nway: WAYS must be 1, 2, 4 or 8");
  end

  // NOTE: the tag and PLRU arrays carry no reset; the sweep engine clears the
  // valid/dirty/PLRU state after reset, so a reset network here buys nothing.
  logic [ENTRY_W-1:0] entry_q [IDX_SIZE][WAYS];
  logic [PLRU_W-1:0]  plru_q  [IDX_SIZE];

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic               idle, req_acc, fill_acc;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic               hit, inv_any;
  logic [WAY_W-1:0]   hit_way, inv_way, plru_victim, resp_way_d;
  logic [PLRU_W-1:0]  plru_hit_upd, plru_fill_upd;
  logic [ENTRY_W-1:0] sel_entry;
  logic [WAY_W-1:0]   unused_fill_victim;
  logic               unused_offset;

  logic             resp_valid_q, resp_hit_q, victim_valid_q, victim_dirty_q;
  logic [WAY_W-1:0] resp_way_q;
  logic [TAG_W-1:0] victim_tag_q;

  assign idle          = (state_q == ST_IDLE);
  assign req_acc       = req_valid && idle;
  assign fill_acc      = fill_valid && idle;
  assign req_tag       = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx       = req_addr[OFFSET_W +: IDX_W];
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  // Sweep FSM: INIT and FLUSH clear one set per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (&cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (flush_start) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Hit and first-invalid search; scanning downward leaves the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (entry_q[req_idx][w][VALID_POS] &&
          entry_q[req_idx][w][ENTRY_W-1:TAG_LSB] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!entry_q[req_idx][w][VALID_POS]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  cache_plru #(.WAYS(WAYS)) u_plru_req (
    .plru_i       (plru_q[req_idx]),
    .access_way_i (hit_way),
    .plru_o       (plru_hit_upd),
    .victim_o     (plru_victim)
  );

  cache_plru #(.WAYS(WAYS)) u_plru_fill (
    .plru_i       (plru_q[fill_idx]),
    .access_way_i (fill_way),
    .plru_o       (plru_fill_upd),
    .victim_o     (unused_fill_victim)
  );

  assign resp_way_d = hit ? hit_way : (inv_any ? inv_way : plru_victim);
  assign sel_entry  = entry_q[req_idx][resp_way_d];

  // Array updates. The fill is written after the hit update in this block, so
  // when both touch the same entry or set PLRU, the fill's value is the one kept.
  always_ff @(posedge iCLK) begin
    if (!idle) begin
      for (int w = 0; w < WAYS; w++) begin
        entry_q[cnt_q][w][VALID_POS] <= 1'b0;
        entry_q[cnt_q][w][DIRTY_POS] <= 1'b0;
      end
      plru_q[cnt_q] <= '0;
    end else begin
      if (req_acc && hit) begin
        plru_q[req_idx] <= plru_hit_upd;
        if (req_write) entry_q[req_idx][hit_way][DIRTY_POS] <= 1'b1;
      end
      if (fill_acc) begin
        entry_q[fill_idx][fill_way] <= {fill_tag, 1'b1, fill_dirty};
        plru_q[fill_idx]            <= plru_fill_upd;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering between blocks is irrelevant.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q        <= ST_INIT;
      cnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_way_q     <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= req_acc;
      if (req_acc) begin
        resp_hit_q     <= hit;
        resp_way_q     <= resp_way_d;
        victim_valid_q <= sel_entry[VALID_POS];
        victim_dirty_q <= sel_entry[DIRTY_POS];
        victim_tag_q   <= sel_entry[ENTRY_W-1:TAG_LSB];
      end
    end
  end

  assign busy         = !idle;
  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign resp_way     = resp_way_q;
  assign victim_valid = victim_valid_q;
  assign victim_dirty = victim_dirty_q;
  assign victim_tag   = victim_tag_q;

endmodule

// File: tb/tb_cache_tag_array_nway.sv
// Self-checking bench for cache_tag_array_nway (default 2-way, 32 sets).
// The reference model keeps per-entry valid/dirty/tag and, per set, the
// most recently used way; with two ways the replacement victim is simply the
// other way.
module tb_cache_tag_array_nway;

  localparam int TAG_W = 25;

  logic              iCLK = 1'b0;
  logic              iRST_N;
  logic              req_valid, req_write, fill_valid, fill_dirty, flush_start;
  logic [31:0]       req_addr;
  logic [4:0]        fill_idx;
  logic [0:0]        fill_way;
  logic [TAG_W-1:0]  fill_tag;
  logic              busy, resp_valid, resp_hit, victim_valid, victim_dirty;
  logic [0:0]        resp_way;
  logic [TAG_W-1:0]  victim_tag;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit               mv [32][2];
  bit               md [32][2];
  bit               mk [32][2];  // tag has been written at least once
  logic [TAG_W-1:0] mt [32][2];
  int               mru [32];

  cache_tag_array_nway dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .fill_valid   (fill_valid),
    .fill_idx     (fill_idx),
    .fill_way     (fill_way),
    .fill_tag     (fill_tag),
    .fill_dirty   (fill_dirty),
    .flush_start  (flush_start),
    .busy         (busy),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    req_valid   = 1'b0;
    req_addr    = '0;
    req_write   = 1'b0;
    fill_valid  = 1'b0;
    fill_idx    = '0;
    fill_way    = '0;
    fill_tag    = '0;
    fill_dirty  = 1'b0;
    flush_start = 1'b0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 32; s++) begin
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
      end
      mru[s] = 0;
    end
  endtask

  // One cycle of stimulus, applied at a falling edge and checked at the next.
  task automatic do_op(input string name, input bit rq, input logic [TAG_W-1:0] rtag,
                       input logic [4:0] ridx, input bit wr, input bit fl,
                       input logic [4:0] fidx, input bit fway, input logic [TAG_W-1:0] ftag,
                       input bit fd, input bit fs);
    bit               e_hit, e_v, e_d, e_k;
    int               e_way;
    logic [TAG_W-1:0] e_t;
    e_hit = 1'b0; e_way = 0; e_v = 1'b0; e_d = 1'b0; e_k = 1'b0; e_t = '0;
    if (rq) begin
      for (int w = 1; w >= 0; w--)
        if (mv[ridx][w] && mt[ridx][w] == rtag) begin e_hit = 1'b1; e_way = w; end
      if (!e_hit) begin
        if (!mv[ridx][0])      e_way = 0;
        else if (!mv[ridx][1]) e_way = 1;
        else                   e_way = 1 - mru[ridx];
      end
      e_v = mv[ridx][e_way];
      e_d = md[ridx][e_way];
      e_k = mk[ridx][e_way];
      e_t = mt[ridx][e_way];
      if (e_hit) begin
        mru[ridx] = e_way;
        if (wr) md[ridx][e_way] = 1'b1;
      end
    end
    if (fl) begin
      mv[fidx][fway] = 1'b1;
      md[fidx][fway] = fd;
      mk[fidx][fway] = 1'b1;
      mt[fidx][fway] = ftag;
      mru[fidx]      = int'(fway);
    end
    req_valid   = rq;
    req_addr    = {rtag, ridx, 2'($urandom_range(0, 3))};
    req_write   = wr;
    fill_valid  = fl;
    fill_idx    = fidx;
    fill_way    = fway;
    fill_tag    = ftag;
    fill_dirty  = fd;
    flush_start = fs;
    @(negedge iCLK);
    drive_idle();
    n_vec++;
    if (!rq) begin
      if (resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s: resp_valid=%b expected 0", name, resp_valid);
      end
    end else begin
      if ({resp_valid, resp_hit, resp_way, victim_valid, victim_dirty} !==
          {1'b1, e_hit, e_way[0], e_v, e_d}) begin
        n_err++;
        $display("FAIL %s: got valid/hit/way/vvalid/vdirty=%b%b%b%b%b expected %b%b%b%b%b",
                 name, resp_valid, resp_hit, resp_way, victim_valid, victim_dirty,
                 1'b1, e_hit, e_way[0], e_v, e_d);
      end
      if (e_k) begin
        n_vec++;
        if (victim_tag !== e_t) begin
          n_err++;
          $display("FAIL %s: victim_tag=%h expected %h", name, victim_tag, e_t);
        end
      end
    end
  endtask

  task automatic lookup(input string name, input logic [TAG_W-1:0] tag, input logic [4:0] idx,
                        input bit wr);
    do_op(name, 1'b1, tag, idx, wr, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill(input string name, input logic [4:0] idx, input bit way,
                      input logic [TAG_W-1:0] tag, input bit dirty);
    do_op(name, 1'b0, '0, '0, 1'b0, 1'b1, idx, way, tag, dirty, 1'b0);
  endtask

  // Counts busy cycles from the current falling edge; optionally hammers the
  // request and fill ports meanwhile and checks that nothing responds.
  task automatic count_busy(input string name, input bit drive_ports);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (drive_ports) begin
        req_valid  = 1'b1;
        req_addr   = $urandom;
        fill_valid = 1'b1;
        fill_idx   = '0;
        fill_way   = 1'($urandom);
        fill_tag   = TAG_W'($urandom);
      end
      @(negedge iCLK);
      cnt++;
      if (drive_ports) begin
        n_vec++;
        if (resp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s_no_resp: resp_valid=%b expected 0 at busy cycle %0d",
                   name, resp_valid, cnt);
        end
      end
    end
    drive_idle();
    n_vec++;
    if (cnt != 32) begin
      n_err++;
      $display("FAIL %s_busy_len: busy cycles=%0d expected 32", name, cnt);
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    drive_idle();
    repeat (2) @(negedge iCLK);
    n_vec++;
    if ({busy, resp_valid, resp_hit, resp_way, victim_valid, victim_dirty, victim_tag} !==
        {1'b1, 30'b0}) begin
      n_err++;
      $display("FAIL reset_state: busy=%b rv=%b hit=%b way=%b vv=%b vd=%b vt=%h expected busy=1 rest 0",
               busy, resp_valid, resp_hit, resp_way, victim_valid, victim_dirty, victim_tag);
    end
    iRST_N = 1'b1;
    count_busy("init", 1'b0);
    model_clear();
    // Address 0x40: tag 0, set 16
    lookup("first_lookup", '0, 5'd16, 1'b0);
  endtask

  task automatic test_fill_hit();
    fill("fill_16_1", 5'd16, 1'b1, 25'h0000123, 1'b0);
    lookup("hit_16_1", 25'h0000123, 5'd16, 1'b0);
  endtask

  task automatic test_write_dirty();
    lookup("write_hit", 25'h0000123, 5'd16, 1'b1);
    lookup("dirty_seen", 25'h0000123, 5'd16, 1'b0);
  endtask

  task automatic test_plru();
    fill("plru_fill0", 5'd3, 1'b0, 25'h00000aa, 1'b0);
    fill("plru_fill1", 5'd3, 1'b1, 25'h00000bb, 1'b1);
    lookup("plru_hit0", 25'h00000aa, 5'd3, 1'b0);
    lookup("plru_victim", 25'h00000cc, 5'd3, 1'b0);
  endtask

  task automatic test_lookup_fill_same();
    do_op("rbw_lookup", 1'b1, 25'h0000abc, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 25'h0000abc, 1'b0, 1'b0);
    lookup("rbw_after", 25'h0000abc, 5'd7, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      do_op("random", ($urandom_range(0, 3) != 0), TAG_W'($urandom_range(16, 19)),
            5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)), 1'($urandom), TAG_W'($urandom_range(16, 19)),
            1'($urandom), 1'b0);
    end
  endtask

  task automatic post_sweep_lookups(input string name);
    for (int s = 0; s < 4; s++) lookup(name, TAG_W'($urandom_range(16, 19)), 5'(s), 1'b0);
    lookup(name, 25'h0000abc, 5'd7, 1'b0);
    lookup(name, 25'h0000123, 5'd16, 1'b0);
    lookup(name, 25'h00000aa, 5'd3, 1'b0);
  endtask

  task automatic test_flush();
    // Request in the same cycle as flush_start is still served.
    do_op("flush_with_req", 1'b1, 25'h0000123, 5'd16, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    count_busy("flush", 1'b1);
    model_clear();
    post_sweep_lookups("after_flush");
  endtask

  task automatic test_reset_mid_sweep();
    fill("pre_fill", 5'd9, 1'b0, 25'h0000555, 1'b1);
    do_op("flush2_start", 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    repeat (10) @(negedge iCLK);
    iRST_N = 1'b0;
    @(negedge iCLK);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_busy: busy=%b expected 1", busy);
    end
    iRST_N = 1'b1;
    count_busy("reinit", 1'b0);
    model_clear();
    lookup("after_reinit", 25'h0000555, 5'd9, 1'b0);
    post_sweep_lookups("after_reinit");
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_write_dirty();
    test_plru();
    test_lookup_fill_same();
    test_random();
    test_flush();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
